// File: rtl/disp_arb_ctrl.sv
// Display arbiter: startup player owns the display until STUP_DONE, then status and
// host sources share it with a minimum dwell per owner. The state register is TMR-voted.
module disp_arb_ctrl #(
  parameter logic [15:0] DWELL = 16'd3000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       STUP_REQ,
  input  logic [7:0] STUP_DATA,
  input  logic       STUP_DONE,
  input  logic       STAT_REQ,
  input  logic [7:0] STAT_DATA,
  input  logic       HOST_REQ,
  input  logic [7:0] HOST_DATA,
  output logic [2:0] GNT,
  output logic [7:0] DISP_DATA,
  output logic       DISP_VALID,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    ST_LOCK = 2'b00,
    ST_IDLE = 2'b01,
    ST_OWN  = 2'b10
  } state_t;

  logic [1:0]  st_a_q, st_b_q, st_c_q, st_vote_s, st_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        last_host_q, last_host_d;
  logic        own_host_s, own_req_s, oth_req_s, dwell_met_s, host_wins_s;
  logic [7:0]  own_data_s;

  assign st_vote_s   = (st_a_q & st_b_q) | (st_a_q & st_c_q) | (st_b_q & st_c_q);
  assign own_host_s  = gnt_q[2];
  assign own_req_s   = own_host_s ? HOST_REQ  : STAT_REQ;
  assign oth_req_s   = own_host_s ? STAT_REQ  : HOST_REQ;
  assign own_data_s  = own_host_s ? HOST_DATA : STAT_DATA;
  assign dwell_met_s = (cnt_q >= DWELL);
  // Host wins by default; alternate to status only when both contend right after a host turn.
  assign host_wins_s = HOST_REQ & ~(STAT_REQ & last_host_q);

  // Next-state and next-output decode from the voted state
  always_comb begin
    st_d        = st_vote_s;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    last_host_d = last_host_q;
    case (st_vote_s)
      ST_LOCK: begin
        cnt_d = 16'd0;
        if (STUP_DONE) begin
          st_d  = ST_IDLE;
          gnt_d = 3'b000;
        end else if (STUP_REQ) begin
          gnt_d   = 3'b001;
          data_d  = STUP_DATA;
          valid_d = 1'b1;
        end else begin
          gnt_d = 3'b000;
        end
      end
      ST_IDLE: begin
        cnt_d = 16'd0;
        if (STAT_REQ || HOST_REQ) begin
          st_d        = ST_OWN;
          gnt_d       = host_wins_s ? 3'b100 : 3'b010;
          last_host_d = host_wins_s;
        end else begin
          st_d  = ST_IDLE;
          gnt_d = 3'b000;
        end
      end
      ST_OWN: begin
        if (own_req_s) begin
          data_d  = own_data_s;
          valid_d = 1'b1;
        end else begin
          data_d = data_q;
        end
        if (dwell_met_s && (!own_req_s || oth_req_s)) begin
          st_d  = ST_IDLE;
          gnt_d = 3'b000;
          cnt_d = 16'd0;
        end else begin
          cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end
      end
      default: begin
        st_d  = ST_LOCK;
        gnt_d = 3'b000;
        cnt_d = 16'd0;
      end
    endcase
  end

  // State copies, dwell counter and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_a_q      <= ST_LOCK;
      st_b_q      <= ST_LOCK;
      st_c_q      <= ST_LOCK;
      cnt_q       <= 16'd0;
      gnt_q       <= 3'b000;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      last_host_q <= 1'b0;
    end else begin
      st_a_q      <= st_d;
      st_b_q      <= st_d;
      st_c_q      <= st_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_host_q <= last_host_d;
    end
  end

  assign GNT        = gnt_q;
  assign DISP_DATA  = data_q;
  assign DISP_VALID = valid_q;
  assign BUSY       = |gnt_q;

endmodule
